// File: rtl/register_file_pkg.sv
// Shared types and constants for the architectural register file and its read ports.
package register_file_pkg;

  localparam int ROB_SIZE      = 31;
  localparam int REG_NUM       = 32;
  localparam int REG_POS_WIDTH = 5;
  localparam int ROB_ID_WIDTH  = $clog2(ROB_SIZE + 1);
  localparam int DATA_WIDTH    = 32;

  typedef logic [REG_POS_WIDTH-1:0] REG_POS_TYPE;
  typedef logic [ROB_ID_WIDTH-1:0]  ROB_ID_TYPE;
  typedef logic [DATA_WIDTH-1:0]    DATA_TYPE;

  localparam REG_POS_TYPE ZERO_REG  = '0;
  localparam ROB_ID_TYPE  ZERO_ROB  = '0;
  localparam DATA_TYPE    ZERO_WORD = '0;
  localparam logic        TRUE      = 1'b1;
  localparam logic        FALSE     = 1'b0;

endpackage

// File: rtl/regfile_read_port.sv
// One dispatcher read port: x0 masking plus the optional same-cycle commit bypass
// (enabled by defining REGFILE_COMMIT_BYPASS_EN).
module regfile_read_port
  import register_file_pkg::*;
(
  input  logic [REG_POS_WIDTH-1:0] rs_i,
  input  logic [DATA_WIDTH-1:0]    data_rd_i,
  input  logic [ROB_ID_WIDTH-1:0]  q_rd_i,
  input  logic                     commit_flag_i,
  input  logic [REG_POS_WIDTH-1:0] rd_from_rob_i,
  input  logic [ROB_ID_WIDTH-1:0]  q_from_rob_i,
  input  logic [DATA_WIDTH-1:0]    v_from_rob_i,
  output logic [DATA_WIDTH-1:0]    v_o,
  output logic [ROB_ID_WIDTH-1:0]  q_o
);

`ifdef REGFILE_COMMIT_BYPASS_EN
  localparam logic BYPASS_EN = TRUE;
`else
  localparam logic BYPASS_EN = FALSE;
`endif

  // Forward only when the retiring tag is still the one this register waits on.
  logic bypass_hit;
  assign bypass_hit = BYPASS_EN && commit_flag_i && (rd_from_rob_i == rs_i) &&
                      (rs_i != ZERO_REG) && (q_rd_i == q_from_rob_i);

  always_comb begin
    v_o = data_rd_i;
    q_o = q_rd_i;
    if (rs_i == ZERO_REG) begin
      v_o = ZERO_WORD;
      q_o = ZERO_ROB;
    end else if (bypass_hit) begin
      v_o = v_from_rob_i;
      q_o = ZERO_ROB;
    end
  end

endmodule

// File: rtl/register_file.sv
// Architectural register file with rename tags: commit writes, rename, rollback.
// Optional same-cycle commit bypass on reads via REGFILE_COMMIT_BYPASS_EN.
module register_file
  import register_file_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rdy,
  input  logic [REG_POS_WIDTH-1:0] rs1_from_dsp,
  input  logic [REG_POS_WIDTH-1:0] rs2_from_dsp,
  output logic [DATA_WIDTH-1:0]    V1_to_dsp,
  output logic [ROB_ID_WIDTH-1:0]  Q1_to_dsp,
  output logic [DATA_WIDTH-1:0]    V2_to_dsp,
  output logic [ROB_ID_WIDTH-1:0]  Q2_to_dsp,
  input  logic                     ena_from_dsp,
  input  logic [REG_POS_WIDTH-1:0] rd_from_dsp,
  input  logic [ROB_ID_WIDTH-1:0]  rob_id_from_dsp,
  input  logic                     commit_flag,
  input  logic [REG_POS_WIDTH-1:0] rd_from_rob,
  input  logic [ROB_ID_WIDTH-1:0]  Q_from_rob,
  input  logic [DATA_WIDTH-1:0]    V_from_rob,
  input  logic                     rollback_flag
);

  logic [DATA_WIDTH-1:0]   data_q [REG_NUM];
  logic [DATA_WIDTH-1:0]   data_d [REG_NUM];
  logic [ROB_ID_WIDTH-1:0] q_q    [REG_NUM];
  logic [ROB_ID_WIDTH-1:0] q_d    [REG_NUM];

  // Order matters: commit clear, then rename overrides it, then rollback wipes all tags.
  always_comb begin
    for (int i = 0; i < REG_NUM; i++) begin
      data_d[i] = data_q[i];
      q_d[i]    = q_q[i];
    end
    for (int i = 1; i < REG_NUM; i++) begin
      if (commit_flag && (rd_from_rob == REG_POS_WIDTH'(i))) begin
        data_d[i] = V_from_rob;
        if (q_q[i] == Q_from_rob) begin
          q_d[i] = ZERO_ROB;
        end
      end
      if (rollback_flag) begin
        q_d[i] = ZERO_ROB;
      end else if (ena_from_dsp && (rd_from_dsp == REG_POS_WIDTH'(i))) begin
        q_d[i] = rob_id_from_dsp;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REG_NUM; i++) begin
        data_q[i] <= ZERO_WORD;
        q_q[i]    <= ZERO_ROB;
      end
    end else if (rdy) begin
      for (int i = 0; i < REG_NUM; i++) begin
        data_q[i] <= data_d[i];
        q_q[i]    <= q_d[i];
      end
    end
  end

  logic [REG_POS_WIDTH-1:0] rs_sel [2];
  logic [DATA_WIDTH-1:0]    v_sel  [2];
  logic [ROB_ID_WIDTH-1:0]  q_sel  [2];

  assign rs_sel[0] = rs1_from_dsp;
  assign rs_sel[1] = rs2_from_dsp;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_read_port
      regfile_read_port u_read_port (
        .rs_i          (rs_sel[gi]),
        .data_rd_i     (data_q[rs_sel[gi]]),
        .q_rd_i        (q_q[rs_sel[gi]]),
        .commit_flag_i (commit_flag),
        .rd_from_rob_i (rd_from_rob),
        .q_from_rob_i  (Q_from_rob),
        .v_from_rob_i  (V_from_rob),
        .v_o           (v_sel[gi]),
        .q_o           (q_sel[gi])
      );
    end
  endgenerate

  assign V1_to_dsp = v_sel[0];
  assign Q1_to_dsp = q_sel[0];
  assign V2_to_dsp = v_sel[1];
  assign Q2_to_dsp = q_sel[1];

endmodule

// File: tb/tb_register_file.sv
// Directed plus randomized bench for register_file, checked against an array-based model.
module tb_register_file;

  logic        clk = 1'b0;
  logic        rst, rdy;
  logic [4:0]  rs1_from_dsp, rs2_from_dsp;
  logic [31:0] V1_to_dsp, V2_to_dsp;
  logic [4:0]  Q1_to_dsp, Q2_to_dsp;
  logic        ena_from_dsp;
  logic [4:0]  rd_from_dsp, rob_id_from_dsp;
  logic        commit_flag;
  logic [4:0]  rd_from_rob, Q_from_rob;
  logic [31:0] V_from_rob;
  logic        rollback_flag;

  int n_checks = 0;
  int n_fails  = 0;

  logic [31:0] m_data [32];
  logic [4:0]  m_q    [32];

  always #5 clk = ~clk;

  register_file dut (
    .clk             (clk),
    .rst             (rst),
    .rdy             (rdy),
    .rs1_from_dsp    (rs1_from_dsp),
    .rs2_from_dsp    (rs2_from_dsp),
    .V1_to_dsp       (V1_to_dsp),
    .Q1_to_dsp       (Q1_to_dsp),
    .V2_to_dsp       (V2_to_dsp),
    .Q2_to_dsp       (Q2_to_dsp),
    .ena_from_dsp    (ena_from_dsp),
    .rd_from_dsp     (rd_from_dsp),
    .rob_id_from_dsp (rob_id_from_dsp),
    .commit_flag     (commit_flag),
    .rd_from_rob     (rd_from_rob),
    .Q_from_rob      (Q_from_rob),
    .V_from_rob      (V_from_rob),
    .rollback_flag   (rollback_flag)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected read under the current (pre-edge) model state and current commit inputs.
  function automatic logic [31:0] exp_v(input logic [4:0] rs);
    if (rs == 0) return 32'h0;
`ifdef REGFILE_COMMIT_BYPASS_EN
    if (commit_flag && rd_from_rob == rs && m_q[rs] == Q_from_rob) return V_from_rob;
`endif
    return m_data[rs];
  endfunction

  function automatic logic [4:0] exp_q(input logic [4:0] rs);
    if (rs == 0) return 5'd0;
`ifdef REGFILE_COMMIT_BYPASS_EN
    if (commit_flag && rd_from_rob == rs && m_q[rs] == Q_from_rob) return 5'd0;
`endif
    return m_q[rs];
  endfunction

  task automatic model_edge();
    logic [4:0] q_old [32];
    if (rst) begin
      for (int i = 0; i < 32; i++) begin m_data[i] = 0; m_q[i] = 0; end
    end else if (rdy) begin
      q_old = m_q;
      if (commit_flag && rd_from_rob != 0) begin
        m_data[rd_from_rob] = V_from_rob;
        if (q_old[rd_from_rob] == Q_from_rob) m_q[rd_from_rob] = 0;
      end
      if (rollback_flag) begin
        for (int i = 0; i < 32; i++) m_q[i] = 0;
      end else if (ena_from_dsp && rd_from_dsp != 0) begin
        m_q[rd_from_dsp] = rob_id_from_dsp;
      end
    end
  endtask

  task automatic idle();
    rst = 0; rdy = 1; ena_from_dsp = 0; rd_from_dsp = 0; rob_id_from_dsp = 0;
    commit_flag = 0; rd_from_rob = 0; Q_from_rob = 0; V_from_rob = 0; rollback_flag = 0;
  endtask

  // Check reads at the falling edge, then advance the model across the rising edge.
  task automatic cycle();
    @(negedge clk);
    check("v1", V1_to_dsp, exp_v(rs1_from_dsp));
    check("q1", {27'd0, Q1_to_dsp}, {27'd0, exp_q(rs1_from_dsp)});
    check("v2", V2_to_dsp, exp_v(rs2_from_dsp));
    check("q2", {27'd0, Q2_to_dsp}, {27'd0, exp_q(rs2_from_dsp)});
    @(posedge clk);
    model_edge();
    #1;
    $display("cycle t=%0t rst=%0b rdy=%0b ena=%0b rd=%0d id=%0d cmt=%0b crd=%0d cq=%0d cv=%0h rb=%0b",
             $time, rst, rdy, ena_from_dsp, rd_from_dsp, rob_id_from_dsp, commit_flag,
             rd_from_rob, Q_from_rob, V_from_rob, rollback_flag);
  endtask

  task automatic rename(input logic [4:0] rd, input logic [4:0] id);
    idle(); ena_from_dsp = 1; rd_from_dsp = rd; rob_id_from_dsp = id; cycle();
  endtask

  task automatic commit(input logic [4:0] rd, input logic [4:0] q, input logic [31:0] v);
    commit_flag = 1; rd_from_rob = rd; Q_from_rob = q; V_from_rob = v;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin m_data[i] = 'x; m_q[i] = 'x; end
    idle(); rs1_from_dsp = 0; rs2_from_dsp = 0;
    rst = 1; rdy = 0;
    @(posedge clk); model_edge(); #1;
    rst = 1; cycle();
    idle();

    // Reset state
    rs1_from_dsp = 5; rs2_from_dsp = 0; #1;
    check("rst_v1", V1_to_dsp, 32'h0); check("rst_q1", {27'd0, Q1_to_dsp}, 32'd0);
    check("rst_v2", V2_to_dsp, 32'h0); check("rst_q2", {27'd0, Q2_to_dsp}, 32'd0);

    // Rename then commit x5
    rename(5, 3); idle(); rs1_from_dsp = 5; #1;
    check("ren_q5", {27'd0, Q1_to_dsp}, 32'd3);
    commit(5, 3, 32'hDEAD); cycle(); idle(); #1;
    check("cmt_v5", V1_to_dsp, 32'hDEAD); check("cmt_q5", {27'd0, Q1_to_dsp}, 32'd0);

    // Stale commit keeps newer tag
    rename(7, 2); rename(7, 6); idle(); commit(7, 2, 32'h11); cycle();
    idle(); rs1_from_dsp = 7; #1;
    check("stale_v7", V1_to_dsp, 32'h11); check("stale_q7", {27'd0, Q1_to_dsp}, 32'd6);

    // Rename overrides commit clear
    rename(9, 4); idle(); commit(9, 4, 32'h22); ena_from_dsp = 1; rd_from_dsp = 9;
    rob_id_from_dsp = 8; cycle(); idle(); rs1_from_dsp = 9; #1;
    check("ovr_v9", V1_to_dsp, 32'h22); check("ovr_q9", {27'd0, Q1_to_dsp}, 32'd8);

    // Rollback with commit and dropped rename
    rename(1, 2); rename(2, 5); idle(); commit(1, 2, 32'h80); rollback_flag = 1;
    ena_from_dsp = 1; rd_from_dsp = 3; rob_id_from_dsp = 7; cycle();
    idle(); rs1_from_dsp = 1; rs2_from_dsp = 3; #1;
    check("rb_v1", V1_to_dsp, 32'h80); check("rb_q1", {27'd0, Q1_to_dsp}, 32'd0);
    check("rb_q3", {27'd0, Q2_to_dsp}, 32'd0);
    rs1_from_dsp = 2; rs2_from_dsp = 9; #1;
    check("rb_q2", {27'd0, Q1_to_dsp}, 32'd0); check("rb_q9", {27'd0, Q2_to_dsp}, 32'd0);

    // rdy=0 freezes; x0 never written
    rename(5, 12); idle(); rdy = 0; commit(5, 12, 32'hBAD); ena_from_dsp = 1; rd_from_dsp = 5;
    rob_id_from_dsp = 9; cycle(); idle(); rs1_from_dsp = 5; #1;
    check("frz_v5", V1_to_dsp, 32'hDEAD); check("frz_q5", {27'd0, Q1_to_dsp}, 32'd12);
    rename(0, 7); idle(); commit(0, 0, 32'hFFFF); cycle(); idle(); rs1_from_dsp = 0; #1;
    check("x0_v", V1_to_dsp, 32'h0); check("x0_q", {27'd0, Q1_to_dsp}, 32'd0);

`ifdef REGFILE_COMMIT_BYPASS_EN
    rename(4, 3); idle(); commit(4, 3, 32'h55); rs1_from_dsp = 4; #1;
    check("byp_v4", V1_to_dsp, 32'h55); check("byp_q4", {27'd0, Q1_to_dsp}, 32'd0);
    cycle();
`endif

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      idle();
      rst           = ($urandom_range(0, 99) == 0);
      rdy           = ($urandom_range(0, 9) != 0);
      rs1_from_dsp  = 5'($urandom_range(0, 7));
      rs2_from_dsp  = 5'($urandom_range(0, 7));
      ena_from_dsp  = ($urandom_range(0, 1) == 1);
      rd_from_dsp   = 5'($urandom_range(0, 7));
      rob_id_from_dsp = 5'($urandom_range(1, 31));
      commit_flag   = ($urandom_range(0, 1) == 1);
      rd_from_rob   = 5'($urandom_range(0, 7));
      Q_from_rob    = ($urandom_range(0, 2) != 0) ? m_q[rd_from_rob] : 5'($urandom_range(1, 31));
      V_from_rob    = $urandom;
      rollback_flag = ($urandom_range(0, 19) == 0);
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
